// File: rtl/control_unit_mc.sv
// control_unit_mc : multicycle MIPS control FSM with memory wait states.
//
// Sits between the instruction register (opcode/funct) and the datapath
// enables and mux selects. All outputs are registered and follow the state
// register. The one exception is pc_write in BRANCH, which also depends on
// the ALU zero flag.
//
// Parameters
//   MEM_WAIT : extra cycles between a memory read request and valid data (0..15)
//   WAIT_W   : width of the wait counter (2**WAIT_W > MEM_WAIT)
//
// Optional build macro
//   CTRL_OVF_EXC_EN : when defined, signed overflow on add/sub/addi diverts
//                     the write-back to the exception state.
//
// Ports
//   i_clock, i_reset_n        : clock (rising edge), async active-low reset
//   i_opcode, i_funct         : IR[31:26], IR[5:0]
//   i_zero, i_overflow        : ALU flags
//   o_rst_out                 : synchronous clear for datapath registers
//   o_*_write                 : register/memory write enables
//   o_exception               : one-cycle pulse in EXC
//   o_iord, o_pc_src, o_alu_op, o_alu_src_a, o_alu_src_b,
//   o_mem_to_reg, o_reg_dst   : datapath selects
//   o_state                   : current state, for debug
//
// state   | meaning
// RESET   | datapath clear, leave one cycle after reset release
// FETCH   | read instruction, PC <= PC + 4
// FWAIT   | instruction fetch wait states
// IRLD    | load IR
// DECODE  | read registers, compute branch target
// EXEC_R  | R-type ALU operation
// WB_R    | write rd
// EXEC_I  | addi/addiu ALU operation
// WB_I    | write rt
// ADDR    | lw/sw address calculation
// MEM_RD  | issue data read
// RWAIT   | data read wait states
// MDRLD   | capture MDR
// WB_MEM  | write rt from MDR
// MEM_WR  | data write
// BRANCH  | compare, conditional PC update
// JUMP    | PC <= jump target
// EXC     | save EPC, PC <= exception vector
module control_unit_mc #(
   parameter int MEM_WAIT = 1,
   parameter int WAIT_W   = 4
) (
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   input  logic       i_zero,
   input  logic       i_overflow,
   output logic       o_rst_out,
   output logic       o_pc_write,
   output logic       o_mem_write,
   output logic       o_ir_write,
   output logic       o_mdr_write,
   output logic       o_reg_write,
   output logic       o_alu_out_write,
   output logic       o_a_write,
   output logic       o_b_write,
   output logic       o_epc_write,
   output logic       o_exception,
   output logic       o_iord,
   output logic [1:0] o_pc_src,
   output logic [2:0] o_alu_op,
   output logic       o_alu_src_a,
   output logic [1:0] o_alu_src_b,
   output logic       o_mem_to_reg,
   output logic       o_reg_dst,
   output logic [4:0] o_state
);

   typedef enum logic [4:0] {
      S_RESET, S_FETCH, S_FWAIT, S_IRLD, S_DECODE, S_EXEC_R, S_WB_R,
      S_EXEC_I, S_WB_I, S_ADDR, S_MEM_RD, S_RWAIT, S_MDRLD, S_WB_MEM,
      S_MEM_WR, S_BRANCH, S_JUMP, S_EXC
   } state_t;

   typedef struct packed {
      logic       rst_out;
      logic       pc_write;
      logic       mem_write;
      logic       ir_write;
      logic       mdr_write;
      logic       reg_write;
      logic       alu_out_write;
      logic       a_write;
      logic       b_write;
      logic       epc_write;
      logic       exception;
      logic       iord;
      logic [1:0] pc_src;
      logic [2:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       mem_to_reg;
      logic       reg_dst;
   } ctrl_t;

   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam bit              LP_HAS_WAIT  = (MEM_WAIT > 0);
   localparam logic [WAIT_W-1:0] LP_WAIT_LOAD = WAIT_W'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);

   state_t              r_state;
   state_t              w_next;
   ctrl_t               r_ctrl;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic [WAIT_W-1:0]   w_next_cnt;
   logic                w_ovf_trap;
   logic                w_br_take;

   function automatic logic [2:0] f_alu_funct(input logic [5:0] fn);
      case (fn)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_OR:   return ALU_OR;
         FN_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

   function automatic logic f_legal_r(input logic [5:0] fn);
      return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
             (fn == FN_OR)  || (fn == FN_SLT);
   endfunction

   function automatic ctrl_t f_decode(input state_t s, input logic [5:0] fn);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.alu_src_b = 2'b01;
            c.alu_op    = ALU_ADD;
            c.pc_write  = 1'b1;
         end
         S_FWAIT, S_RWAIT: ;
         S_IRLD:  c.ir_write = 1'b1;
         S_DECODE: begin
            c.a_write       = 1'b1;
            c.b_write       = 1'b1;
            c.alu_src_b     = 2'b11;
            c.alu_op        = ALU_ADD;
            c.alu_out_write = 1'b1;
         end
         S_EXEC_R: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = f_alu_funct(fn);
            c.alu_out_write = 1'b1;
         end
         S_WB_R: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_EXEC_I, S_ADDR: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = 2'b10;
            c.alu_op        = ALU_ADD;
            c.alu_out_write = 1'b1;
         end
         S_WB_I:  c.reg_write = 1'b1;
         S_MEM_RD: c.iord = 1'b1;
         S_MDRLD: c.mdr_write = 1'b1;
         S_WB_MEM: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            c.iord      = 1'b1;
            c.mem_write = 1'b1;
         end
         // pc_write here comes from the zero flag, see w_br_take
         S_BRANCH: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = ALU_SUB;
            c.pc_src    = 2'b01;
         end
         S_JUMP: begin
            c.pc_src   = 2'b10;
            c.pc_write = 1'b1;
         end
         S_EXC: begin
            c.epc_write = 1'b1;
            c.exception = 1'b1;
            c.pc_src    = 2'b11;
            c.pc_write  = 1'b1;
         end
         default: c.rst_out = 1'b1;
      endcase
      return c;
   endfunction

`ifdef CTRL_OVF_EXC_EN
   // Overflow is taken at the end of the execute cycle and steers the next
   // state straight into EXC, so the write-back state is never entered.
   assign w_ovf_trap = i_overflow &
                       (((r_state == S_EXEC_R) && ((i_funct == FN_ADD) || (i_funct == FN_SUB))) ||
                        ((r_state == S_EXEC_I) && (i_opcode == 6'd8)));
`else
   logic w_unused_ovf;
   assign w_unused_ovf = i_overflow;
   assign w_ovf_trap   = 1'b0;
`endif

   always_comb begin
      w_next     = r_state;
      w_next_cnt = r_wait_cnt;
      case (r_state)
         S_RESET: w_next = S_FETCH;
         S_FETCH: begin
            if (LP_HAS_WAIT) begin
               w_next     = S_FWAIT;
               w_next_cnt = LP_WAIT_LOAD;
            end else begin
               w_next = S_IRLD;
            end
         end
         S_FWAIT: begin
            if (r_wait_cnt == '0) w_next = S_IRLD;
            else                  w_next_cnt = r_wait_cnt - WAIT_W'(1);
         end
         S_IRLD: w_next = S_DECODE;
         S_DECODE: begin
            if ((i_opcode == 6'd0) && f_legal_r(i_funct))     w_next = S_EXEC_R;
            else if ((i_opcode == 6'd8) || (i_opcode == 6'd9))  w_next = S_EXEC_I;
            else if ((i_opcode == 6'd35) || (i_opcode == 6'd43)) w_next = S_ADDR;
            else if ((i_opcode == 6'd4) || (i_opcode == 6'd5))  w_next = S_BRANCH;
            else if (i_opcode == 6'd2)                          w_next = S_JUMP;
            else                                                w_next = S_EXC;
         end
         S_EXEC_R: w_next = w_ovf_trap ? S_EXC : S_WB_R;
         S_EXEC_I: w_next = w_ovf_trap ? S_EXC : S_WB_I;
         S_ADDR:   w_next = (i_opcode == 6'd35) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: begin
            if (LP_HAS_WAIT) begin
               w_next     = S_RWAIT;
               w_next_cnt = LP_WAIT_LOAD;
            end else begin
               w_next = S_MDRLD;
            end
         end
         S_RWAIT: begin
            if (r_wait_cnt == '0) w_next = S_MDRLD;
            else                  w_next_cnt = r_wait_cnt - WAIT_W'(1);
         end
         S_MDRLD: w_next = S_WB_MEM;
         default: w_next = S_FETCH;
      endcase
   end

   // Outputs are decoded from the next state and registered alongside it,
   // so they line up with r_state without a combinational decode stage.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= S_RESET;
         r_wait_cnt <= '0;
         r_ctrl     <= f_decode(S_RESET, 6'd0);
      end else begin
         r_state    <= w_next;
         r_wait_cnt <= w_next_cnt;
         r_ctrl     <= f_decode(w_next, i_funct);
      end
   end

   // beq (opcode 4) writes on zero, bne (opcode 5) on not-zero
   assign w_br_take = (r_state == S_BRANCH) & (i_opcode[0] ? ~i_zero : i_zero);

   assign o_rst_out       = r_ctrl.rst_out;
   assign o_pc_write      = r_ctrl.pc_write | w_br_take;
   assign o_mem_write     = r_ctrl.mem_write;
   assign o_ir_write      = r_ctrl.ir_write;
   assign o_mdr_write     = r_ctrl.mdr_write;
   assign o_reg_write     = r_ctrl.reg_write;
   assign o_alu_out_write = r_ctrl.alu_out_write;
   assign o_a_write       = r_ctrl.a_write;
   assign o_b_write       = r_ctrl.b_write;
   assign o_epc_write     = r_ctrl.epc_write;
   assign o_exception     = r_ctrl.exception;
   assign o_iord          = r_ctrl.iord;
   assign o_pc_src        = r_ctrl.pc_src;
   assign o_alu_op        = r_ctrl.alu_op;
   assign o_alu_src_a     = r_ctrl.alu_src_a;
   assign o_alu_src_b     = r_ctrl.alu_src_b;
   assign o_mem_to_reg    = r_ctrl.mem_to_reg;
   assign o_reg_dst       = r_ctrl.reg_dst;
   assign o_state         = r_state;

endmodule
